// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory controller
//
// Purpose: FSM state encoding, default word/address widths and the width of
// the per-access wait-state counter.
package lc3_mem_pkg;

  // Default word width (also the MAR width) and RAM address width.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  // Wait-state counter width; supports 0..15 extra cycles per RAM access.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/lc3_sync_ram.sv
// rtl/lc3_sync_ram.sv - single-port synchronous RAM with registered read data
//
// Purpose: backing store for lc3_mem_ctrl. Write commits on the rising edge
// when wren is high; q returns the word at addr one cycle after the address
// edge. Contents are never reset.
//
// Ports:
//   CLK    in   clock
//   addr   in   ADDR_W  word address
//   wdata  in   DATA_W  write data
//   wren   in   write enable
//   q      out  DATA_W  registered read data
module lc3_sync_ram
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] q_q;

  // Read-before-write: q during a write cycle carries the old word and is
  // ignored by the controller.
  always_ff @(posedge CLK) begin
    if (wren) begin
      mem_q[addr] <= wdata;
    end
    q_q <= mem_q[addr];
  end

  assign q = q_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory data path with direct/indirect access
//
// Purpose: owns MAR, write-data register (WDR), read-data register (MDR) and
// the RAM. Runs direct and pointer-chasing (LDI/STI-style) reads and writes
// under a REQ/BUSY/DONE handshake with WAIT_STATES extra cycles per access.
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   REQ       in   start request, accepted in IDLE or DONE
//   WE_REQ    in   final access is a write (1) or read (0)
//   INDIRECT  in   ADDR_IN holds a pointer to the effective address
//   ADDR_IN   in   DATA_W  request address
//   WR_DATA   in   DATA_W  store data
//   RD_DATA   out  DATA_W  last final-read result
//   MAR       out  DATA_W  memory address register
//   BUSY      out  high in ACCESS and CAPTURE
//   DONE      out  one-cycle completion pulse
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE_REQ,
  input  logic              INDIRECT,
  input  logic [DATA_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] MAR,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] wdr_q, wdr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;  // 1: pointer fetch still pending
  logic              we_q, we_d;

  logic              ram_we;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      wdr_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      wdr_q   <= wdr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    wdr_d   = wdr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    we_d    = we_q;
    ram_we  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts like IDLE so REQ held high chains operations.
        if (REQ) begin
          mar_d   = ADDR_IN;
          wdr_d   = WR_DATA;
          we_d    = WE_REQ;
          phase_d = INDIRECT;
          cnt_d   = WAIT_INIT;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!phase_q && we_q) begin
          ram_we  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (phase_q) begin
          // Pointer fetched: keep all DATA_W bits, RAM uses the low ADDR_W.
          mar_d   = ram_q;
          phase_d = 1'b0;
          cnt_d   = WAIT_INIT;
          state_d = ST_ACCESS;
        end else begin
          rd_d    = ram_q;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A write whose commit edge sees RST is dropped.
  assign ram_wren = ram_we & ~RST;

  lc3_sync_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK   (CLK),
    .addr  (mar_q[ADDR_W-1:0]),
    .wdata (wdr_q),
    .wren  (ram_wren),
    .q     (ram_q)
  );

  assign RD_DATA = rd_q;
  assign MAR     = mar_q;
  assign BUSY    = (state_q == ST_ACCESS) || (state_q == ST_CAPTURE);
  assign DONE    = (state_q == ST_DONE);

endmodule
